// File: rtl/dp_sequencer.sv
// Instruction sequencer: 2-entry in-order FIFO feeding a READ/EXEC/WRITE
// control FSM that drives register-bank enables and datapath fields.
module dp_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic        Rd1,
    output logic        Rd2,
    output logic        Wr,
    output logic [3:0]  src1,
    output logic [3:0]  src2,
    output logic [3:0]  dest,
    output logic [3:0]  opcode,
    output logic        busy,
    output logic        done,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] fifo_mem_q [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] cur_q, cur_d;
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] retired_q, retired_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    assign fifo_full  = (count_q == 2'd2);
    assign fifo_empty = (count_q == 2'd0);
    assign push       = instr_valid && !fifo_full;
    // The FSM only takes a new instruction when it is free to start READ next cycle.
    assign pop        = !fifo_empty && ((state_q == IDLE) || (state_q == WRITE));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        cur_d     = cur_q;
        retired_d = retired_q;

        case (state_q)
            IDLE:    if (pop) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = WRITE;
            WRITE: begin
                state_d   = pop ? READ : IDLE;
                retired_d = retired_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            cur_d    = fifo_mem_q[rd_ptr_q];
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Enables are registered so they line up with the state they describe.
        rd_en_d = (state_d != IDLE);
        wr_en_d = (state_d == WRITE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            cur_q     <= 16'd0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            retired_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            cur_q     <= cur_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            retired_q <= retired_d;
        end
    end

    // NOTE: FIFO storage is not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= instr;
        end
    end

    assign instr_ready = !fifo_full;
    assign Rd1         = rd_en_q;
    assign Rd2         = rd_en_q;
    assign Wr          = wr_en_q;
    assign done        = wr_en_q;
    assign opcode      = cur_q[15:12];
    assign dest        = cur_q[11:8];
    assign src1        = cur_q[7:4];
    assign src2        = cur_q[3:0];
    assign busy        = (state_q != IDLE) || !fifo_empty;
    assign retired     = retired_q;

endmodule
